// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter
//   Two-requester arbiter that serialises 32-bit word accesses onto an
//   8-bit system bus as four byte strobes (little-endian, byte 0 first).
//   A burst takes six cycles:
//     - four byte cycles with the strobe high;
//     - one drain cycle in which the last read byte arrives;
//     - one DONE cycle that pulses the owner's done.
//   The block then spends at least one cycle in IDLE before the next grant.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   req0/1, rw0/1         burst request, direction (1 = read)
//   addr0/1, wdata0/1     word address (bits [1:0] ignored), write word
//   gnt0/1, done0/1       grant (whole burst), one-cycle completion pulse
//   rdata                 assembled read word
//   sysaddress            system byte address
//   sysdata_out           system write byte
//   sysdata_in            system read byte, valid the cycle after its strobe
//   sysrw, sysstrobe      system direction and byte strobe
//
// Configuration
//   SYSBUS_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie.
//                             Otherwise ties are resolved round-robin,
//                             favouring requester 0 after reset.
module sysbus_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] sysaddress,
    output logic [7:0]        sysdata_out,
    input  logic [7:0]        sysdata_in,
    output logic              sysrw,
    output logic              sysstrobe
);

    typedef enum logic [2:0] {IDLE, BYTE0, BYTE1, BYTE2, BYTE3, DONE} state_t;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
        return w[8*k +: 8];
    endfunction

    state_t            state_q, state_d;
    logic              tail_q, tail_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              strobe_q, strobe_d;
    logic [ADDR_W-1:0] sysaddr_q, sysaddr_d;
    logic [7:0]        sysdout_q, sysdout_d;
    logic              sysrw_q, sysrw_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              cap_en_q, cap_en_d;
    logic [1:0]        cap_idx_q, cap_idx_d;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
    logic              prio_q, prio_d;   // 1 = requester 1 is favoured on a tie
`endif

    logic              pick1;
    logic              issue;
    logic [1:0]        issue_idx;

    // Word addresses carry no byte offset; the low bits are dropped on entry.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{addr0[1:0], addr1[1:0]};

`ifdef SYSBUS_ARB_FIXED_PRIO_EN
    assign pick1 = req1 && !req0;
`else
    assign pick1 = req1 && (!req0 || prio_q);
`endif

    always_comb begin
        state_d   = state_q;
        tail_d    = tail_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt_d     = gnt_q;
        done_d    = 2'b00;
        strobe_d  = 1'b0;
        sysaddr_d = sysaddr_q;
        sysdout_d = sysdout_q;
        sysrw_d   = sysrw_q;
        rdata_d   = rdata_q;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
        prio_d    = prio_q;
`endif
        issue     = 1'b0;
        issue_idx = 2'd0;

        // A read byte shows up on sysdata_in one cycle after its strobe;
        // the strobed byte index is remembered for that capture.
        cap_en_d  = strobe_q && sysrw_q;
        cap_idx_d = sysaddr_q[1:0];
        if (cap_en_q) begin
            rdata_d[8*cap_idx_q +: 8] = sysdata_in;
        end

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    rw_d    = pick1 ? rw1 : rw0;
                    addr_d  = pick1 ? addr1[ADDR_W-1:2] : addr0[ADDR_W-1:2];
                    wdata_d = pick1 ? wdata1 : wdata0;
                    gnt_d   = {pick1, !pick1};
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
                    prio_d  = !pick1;
`endif
                    issue     = 1'b1;
                    issue_idx = 2'd0;
                    state_d   = BYTE0;
                end
            end
            BYTE0: begin
                issue     = 1'b1;
                issue_idx = 2'd1;
                state_d   = BYTE1;
            end
            BYTE1: begin
                issue     = 1'b1;
                issue_idx = 2'd2;
                state_d   = BYTE2;
            end
            BYTE2: begin
                issue     = 1'b1;
                issue_idx = 2'd3;
                state_d   = BYTE3;
            end
            BYTE3: begin
                // BYTE3 lasts two cycles: the strobe cycle, then a drain
                // cycle (strobe low) whose closing edge captures byte 3.
                if (!tail_q) begin
                    tail_d = 1'b1;
                end else begin
                    tail_d  = 1'b0;
                    done_d  = gnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                tail_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Byte issue uses the freshly latched request fields, so the first
        // strobe appears in the cycle right after the grant edge.
        if (issue) begin
            strobe_d  = 1'b1;
            sysaddr_d = {addr_d, issue_idx};
            sysrw_d   = rw_d;
            sysdout_d = byte_sel(wdata_d, issue_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tail_q    <= 1'b0;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            strobe_q  <= 1'b0;
            sysaddr_q <= '0;
            sysdout_q <= '0;
            sysrw_q   <= 1'b1;
            rdata_q   <= '0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= 2'd0;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
            prio_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tail_q    <= tail_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            strobe_q  <= strobe_d;
            sysaddr_q <= sysaddr_d;
            sysdout_q <= sysdout_d;
            sysrw_q   <= sysrw_d;
            rdata_q   <= rdata_d;
            cap_en_q  <= cap_en_d;
            cap_idx_q <= cap_idx_d;
`ifndef SYSBUS_ARB_FIXED_PRIO_EN
            prio_q    <= prio_d;
`endif
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign done0       = done_q[0];
    assign done1       = done_q[1];
    assign rdata       = rdata_q;
    assign sysaddress  = sysaddr_q;
    assign sysdata_out = sysdout_q;
    assign sysrw       = sysrw_q;
    assign sysstrobe   = strobe_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: read burst, write burst, arbitration
// under continuous contention, request drop mid-burst, reset mid-burst.
// Cycle Cn is the cycle following the n-th edge of a burst (E1 samples req).
module tb_sysbus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, rw0, rw1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] rdata;
    logic [15:0] sysaddress;
    logic [7:0]  sysdata_out;
    logic [7:0]  sysdata_in;
    logic        sysrw, sysstrobe;

    int checks   = 0;
    int failures = 0;

    sysbus_arbiter #(.ADDR_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .sysaddress(sysaddress), .sysdata_out(sysdata_out),
        .sysdata_in(sysdata_in), .sysrw(sysrw), .sysstrobe(sysstrobe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".gnt"},     {30'd0, gnt1, gnt0},   32'd0);
        check({tag, ".done"},    {30'd0, done1, done0}, 32'd0);
        check({tag, ".strobe"},  {31'd0, sysstrobe},    32'd0);
        check({tag, ".sysrw"},   {31'd0, sysrw},        32'd1);
        check({tag, ".addr"},    {16'd0, sysaddress},   32'd0);
        check({tag, ".dout"},    {24'd0, sysdata_out},  32'd0);
        check({tag, ".rdata"},   rdata,                 32'd0);
    endtask

    initial begin
        logic [7:0]  rd_bytes [4];
        logic [7:0]  wr_bytes [4];
        logic        exp1;

        reset = 1'b1; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; sysdata_in = '0;
        tick(); tick();
        check_reset_vals("rst");
        reset = 1'b0;

        // Read burst on requester 0.
        rd_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        req0 = 1; rw0 = 1; addr0 = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            tick();                                   // C(k+1)
            if (k == 0) req0 = 0;
            check($sformatf("rd.c%0d.gnt0", k+1),   {31'd0, gnt0},      32'd1);
            check($sformatf("rd.c%0d.strobe", k+1), {31'd0, sysstrobe}, 32'd1);
            check($sformatf("rd.c%0d.addr", k+1),   {16'd0, sysaddress}, 32'h1234 + k);
            check($sformatf("rd.c%0d.rw", k+1),     {31'd0, sysrw},     32'd1);
            if (k > 0) sysdata_in = rd_bytes[k-1];
        end
        tick();                                       // C5
        sysdata_in = rd_bytes[3];
        check("rd.c5.strobe", {31'd0, sysstrobe}, 32'd0);
        check("rd.c5.done0",  {31'd0, done0},     32'd0);
        check("rd.c5.gnt0",   {31'd0, gnt0},      32'd1);
        tick();                                       // C6
        check("rd.c6.done",  {30'd0, done1, done0}, 32'd1);
        check("rd.c6.gnt",   {30'd0, gnt1, gnt0},   32'd1);
        check("rd.c6.rdata", rdata,                 32'hDDCCBBAA);
        tick();                                       // C7
        check("rd.c7.gnt",   {30'd0, gnt1, gnt0},   32'd0);
        check("rd.c7.done",  {30'd0, done1, done0}, 32'd0);
        check("rd.c7.hold",  {16'd0, sysaddress},   32'h1237);

        // Write burst on requester 1.
        wr_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};
        req1 = 1; rw1 = 0; addr1 = 16'h00F3; wdata1 = 32'h11223344;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) req1 = 0;
            check($sformatf("wr.c%0d.gnt", k+1),  {30'd0, gnt1, gnt0},  32'd2);
            check($sformatf("wr.c%0d.addr", k+1), {16'd0, sysaddress},  32'h00F0 + k);
            check($sformatf("wr.c%0d.dout", k+1), {24'd0, sysdata_out}, {24'd0, wr_bytes[k]});
            check($sformatf("wr.c%0d.rw", k+1),   {31'd0, sysrw},       32'd0);
            check($sformatf("wr.c%0d.stb", k+1),  {31'd0, sysstrobe},   32'd1);
        end
        tick();
        check("wr.c5.done", {30'd0, done1, done0}, 32'd0);
        tick();
        check("wr.c6.done",  {30'd0, done1, done0}, 32'd2);
        check("wr.c6.rdata", rdata,                 32'hDDCCBBAA);
        check("wr.c6.stb",   {31'd0, sysstrobe},    32'd0);
        tick();
        check("wr.c7.gnt", {30'd0, gnt1, gnt0}, 32'd0);

        // Continuous contention from reset.
        reset = 1'b1; tick(); reset = 1'b0;
        req0 = 1; req1 = 1; rw0 = 1; rw1 = 1; addr0 = 16'h0100; addr1 = 16'h0200;
        for (int b = 0; b < 4; b++) begin
            tick();                                   // C1
`ifdef SYSBUS_ARB_FIXED_PRIO_EN
            exp1 = 1'b0;
`else
            exp1 = b[0];
`endif
            check($sformatf("rr.b%0d.gnt", b), {30'd0, gnt1, gnt0}, exp1 ? 32'd2 : 32'd1);
            repeat (2) tick();                        // C3
            check($sformatf("rr.b%0d.c3gnt", b), {30'd0, gnt1, gnt0}, exp1 ? 32'd2 : 32'd1);
            repeat (3) tick();                        // C6
            check($sformatf("rr.b%0d.done", b), {30'd0, done1, done0}, exp1 ? 32'd2 : 32'd1);
            tick();                                   // C7
            check($sformatf("rr.b%0d.idle", b), {30'd0, gnt1, gnt0}, 32'd0);
        end
        req0 = 0; req1 = 0;
        tick(); tick();

        // Requester 0 drops its request in C2; burst still completes.
        rd_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        req0 = 1; rw0 = 1; addr0 = 16'h0040;
        tick();                                       // C1
        tick();                                       // C2
        req0 = 0;
        sysdata_in = rd_bytes[0];
        tick(); sysdata_in = rd_bytes[1];             // C3
        tick(); sysdata_in = rd_bytes[2];             // C4
        tick(); sysdata_in = rd_bytes[3];             // C5
        check("drop.c5.gnt0", {31'd0, gnt0}, 32'd1);
        tick();                                       // C6
        check("drop.c6.done",  {30'd0, done1, done0}, 32'd1);
        check("drop.c6.rdata", rdata,                 32'h04030201);
        tick();

        // Reset in C3 of a requester-1 burst.
        req1 = 1; rw1 = 0; addr1 = 16'h0ABC; wdata1 = 32'hCAFEF00D;
        tick();                                       // C1
        req1 = 0;
        tick(); tick();                               // C3
        check("mid.c3.gnt1", {31'd0, gnt1}, 32'd1);
        reset = 1'b1;
        tick();
        check_reset_vals("mid");
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("mid.nodone%0d", c), {30'd0, done1, done0}, 32'd0);
        end
        req1 = 1;
        tick();                                       // C1
        req1 = 0;
        check("mid.regnt",  {30'd0, gnt1, gnt0}, 32'd2);
        check("mid.addr",   {16'd0, sysaddress}, 32'h0ABC);
        check("mid.dout",   {24'd0, sysdata_out}, 32'h0D);
        repeat (5) tick();                            // C6
        check("mid.done1",  {30'd0, done1, done0}, 32'd2);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
